// File: rtl/educ8_major_state_ctrl.sv
// EDUC-8 major-state and timing-pulse sequencer.
// Steps FETCH / DEFER / EXECUTE major cycles of eight timing states each, applies the
// front-panel run / halt / single-step controls, and drives registered one-hot timing
// and major-state lines for the datapath.

module educ8_major_state_ctrl #(
    parameter int unsigned NT = 8
) (
    input  logic       clk,
    input  logic       nclr,
    input  logic       run,
    input  logic       halt,
    input  logic       sstep,
    input  logic [2:0] opcode,
    input  logic       ind,
    output logic [7:0] tp,
    output logic [2:0] major,
    output logic       running,
    output logic       instr_done
);

    // One-hot major-state encoding; the value is driven straight onto the major output.
    typedef enum logic [2:0] {
        MajFetch = 3'b001,
        MajDefer = 3'b010,
        MajExec  = 3'b100
    } major_e;

    localparam logic [2:0] TcLast = 3'(NT - 1);
    localparam logic [2:0] OpJmp  = 3'd5;
    localparam logic [2:0] OpIot  = 3'd6;

    // Architectural state.
    major_e     r_major;
    logic [2:0] r_tc;
    logic [7:0] r_tp;
    logic       r_running;
    logic       r_instr_done;
    logic       r_halt_req;
    logic       r_run_q;

    // Decode of the current state and inputs.
    major_e     w_next_major;
    logic       w_mem_ref;
    logic       w_run_rise;
    logic       w_last;
    logic       w_instr_end;
    logic       w_stop;
    logic       w_major_ok;

    // Opcodes 0-5 reference memory; IOT and OPR finish inside the fetch cycle.
    assign w_mem_ref  = (opcode < OpIot);
    assign w_run_rise = run & ~r_run_q;
    assign w_last     = (r_tc == TcLast);
    assign w_major_ok = (r_major == MajFetch) | (r_major == MajDefer) | (r_major == MajExec);

    // Next major state, taken on the edge that ends T7.
    always_comb begin
        w_next_major = MajFetch;
        unique case (r_major)
            MajFetch: begin
                if (!w_mem_ref) begin
                    w_next_major = MajFetch;
                end else if (ind) begin
                    w_next_major = MajDefer;
                end else if (opcode == OpJmp) begin
                    w_next_major = MajFetch;
                end else begin
                    w_next_major = MajExec;
                end
            end
            // Indirect JMP completes once the effective address is fetched. An IOT/OPR
            // opcode here can only come from an IR change mid-instruction; treat it as
            // complete rather than running an execute cycle for it.
            MajDefer: begin
                if (w_mem_ref && (opcode != OpJmp)) begin
                    w_next_major = MajExec;
                end else begin
                    w_next_major = MajFetch;
                end
            end
            MajExec: begin
                w_next_major = MajFetch;
            end
            default: begin
                w_next_major = MajFetch;
            end
        endcase
    end

    // Instruction end and the stop decision for the current T7.
    assign w_instr_end = (w_next_major == MajFetch);
    assign w_stop      = sstep | ((r_halt_req | halt) & w_instr_end);

    // Sequencer: timing counter, major state, run/halt control and registered outputs.
    always_ff @(posedge clk or negedge nclr) begin
        if (!nclr) begin
            r_major      <= MajFetch;
            r_tc         <= 3'd0;
            r_tp         <= 8'h00;
            r_running    <= 1'b0;
            r_instr_done <= 1'b0;
            r_halt_req   <= 1'b0;
            r_run_q      <= 1'b0;
        end else begin
            r_run_q      <= run;
            r_instr_done <= 1'b0;

            if (!r_running) begin
                // Stopped: tc and major hold; only a fresh run edge does anything.
                if (w_run_rise) begin
                    r_running  <= 1'b1;
                    r_tc       <= 3'd0;
                    r_tp       <= 8'h01;
                    r_halt_req <= 1'b0;
                end else begin
                    r_tp <= 8'h00;
                end
            end else begin
                if (halt) begin
                    r_halt_req <= 1'b1;
                end

                if (w_last) begin
                    r_major      <= w_next_major;
                    r_instr_done <= w_instr_end;
                    r_tc         <= 3'd0;
                    if (w_stop) begin
                        r_running  <= 1'b0;
                        r_tp       <= 8'h00;
                        r_halt_req <= 1'b0;
                    end else begin
                        r_tp <= 8'h01;
                    end
                end else begin
                    r_tc <= r_tc + 3'd1;
                    r_tp <= 8'h01 << (r_tc + 3'd1);
                end
            end

            // Recover from a corrupted major encoding regardless of run state.
            if (!w_major_ok) begin
                r_major <= MajFetch;
            end
        end
    end

    assign tp         = r_tp;
    assign major      = r_major;
    assign running    = r_running;
    assign instr_done = r_instr_done;

endmodule

// File: tb/tb_educ8_major_state_ctrl.sv
// Self-checking bench for educ8_major_state_ctrl: a vector table from reset, hand-written
// multi-cycle sequences, and randomized panel/IR stimulus against a reference model.

module tb_educ8_major_state_ctrl;

    logic       clk;
    logic       nclr;
    logic       run;
    logic       halt;
    logic       sstep;
    logic [2:0] opcode;
    logic       ind;
    logic [7:0] tp;
    logic [2:0] major;
    logic       running;
    logic       instr_done;

    int n_checks = 0;
    int n_errors = 0;

    educ8_major_state_ctrl #(
        .NT(8)
    ) dut (
        .clk       (clk),
        .nclr      (nclr),
        .run       (run),
        .halt      (halt),
        .sstep     (sstep),
        .opcode    (opcode),
        .ind       (ind),
        .tp        (tp),
        .major     (major),
        .running   (running),
        .instr_done(instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       run;
        logic       halt;
        logic       sstep;
        logic [2:0] opc;
        logic       ind;
        logic [7:0] e_tp;
        logic [2:0] e_maj;
        logic       e_run;
        logic       e_done;
    } vec_t;

    vec_t vecs[12];

    // Reference model: major cycles as indices 0=FETCH 1=DEFER 2=EXEC.
    bit m_running;
    int m_cnt;
    int m_maj;
    bit m_hreq;
    bit m_runq;
    bit m_done;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_tp, input logic [2:0] e_maj,
                              input logic e_run, input logic e_done);
        check({tag, ".tp"}, tp, e_tp);
        check({tag, ".major"}, 8'(major), 8'(e_maj));
        check({tag, ".running"}, 8'(running), 8'(e_run));
        check({tag, ".instr_done"}, 8'(instr_done), 8'(e_done));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        nclr   = 1'b0;
        run    = 1'b0;
        halt   = 1'b0;
        sstep  = 1'b0;
        opcode = 3'd0;
        ind    = 1'b0;
        tick();
        check_outs("reset", 8'h00, 3'b001, 1'b0, 1'b0);
        nclr = 1'b1;
    endtask

    task automatic start();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    // Path of major cycles an instruction walks through, starting with FETCH.
    function automatic int next_major(input int maj, input int opc, input bit ib);
        int path[$];
        if (maj == 2) return 0;
        path.push_back(0);
        if (opc < 6) begin
            if (ib || maj == 1) path.push_back(1);
            if (opc != 5) path.push_back(2);
        end
        for (int i = 0; i + 1 < path.size(); i++) begin
            if (path[i] == maj) return path[i + 1];
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_running = 0;
        m_cnt     = 0;
        m_maj     = 0;
        m_hreq    = 0;
        m_runq    = 0;
        m_done    = 0;
    endtask

    // One clock of the reference, using the inputs present at the edge.
    task automatic model_step();
        bit stop;
        int nm;
        m_done = 0;
        if (!m_running) begin
            if (run && !m_runq) begin
                m_running = 1;
                m_cnt     = 0;
                m_hreq    = 0;
            end
        end else if (m_cnt == 7) begin
            nm     = next_major(m_maj, int'(opcode), ind);
            m_done = (nm == 0);
            stop   = sstep || ((m_hreq || halt) && m_done);
            m_maj  = nm;
            m_cnt  = 0;
            m_hreq = m_hreq || halt;
            if (stop) begin
                m_running = 0;
                m_hreq    = 0;
            end
        end else begin
            m_cnt++;
            m_hreq = m_hreq || halt;
        end
        m_runq = run;
    endtask

    initial begin
        // Start latency and fetch-only stepping from reset.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 3'b001, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h01, 3'b001, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h02, 3'b001, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h04, 3'b001, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h08, 3'b001, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h10, 3'b001, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h20, 3'b001, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h40, 3'b001, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h80, 3'b001, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 8'h01, 3'b001, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 8'h02, 3'b001, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 8'h04, 3'b001, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            run    = vecs[i].run;
            halt   = vecs[i].halt;
            sstep  = vecs[i].sstep;
            opcode = vecs[i].opc;
            ind    = vecs[i].ind;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_tp, vecs[i].e_maj, vecs[i].e_run,
                       vecs[i].e_done);
        end

        // Indirect TAD: 8 clocks each of FETCH, DEFER, EXEC.
        do_reset();
        opcode = 3'd1;
        ind    = 1'b1;
        start();
        check_outs("itad_k0", 8'h01, 3'b001, 1'b1, 1'b0);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_outs($sformatf("itad_k%0d", k), 8'(1 << (k % 8)), 3'(1 << ((k % 24) / 8)),
                       1'b1, 1'((k % 24) == 0));
        end

        // Indirect JMP: FETCH, DEFER, FETCH, never EXEC.
        do_reset();
        opcode = 3'd5;
        ind    = 1'b1;
        start();
        for (int k = 1; k <= 33; k++) begin
            tick();
            check_outs($sformatf("ijmp_k%0d", k), 8'(1 << (k % 8)), 3'(1 << ((k % 16) / 8)),
                       1'b1, 1'((k % 16) == 0));
        end

        // Direct JMP: fetch only.
        do_reset();
        opcode = 3'd5;
        ind    = 1'b0;
        start();
        for (int k = 1; k <= 17; k++) begin
            tick();
            check_outs($sformatf("djmp_k%0d", k), 8'(1 << (k % 8)), 3'b001, 1'b1,
                       1'((k % 8) == 0));
        end

        // Single step through a direct ISZ.
        do_reset();
        sstep  = 1'b1;
        opcode = 3'd2;
        ind    = 1'b0;
        start();
        tick_n(7);
        check_outs("ss_t7", 8'h80, 3'b001, 1'b1, 1'b0);
        tick();
        check_outs("ss_stop1", 8'h00, 3'b100, 1'b0, 1'b0);
        tick_n(4);
        check_outs("ss_hold", 8'h00, 3'b100, 1'b0, 1'b0);
        start();
        check_outs("ss_resume", 8'h01, 3'b100, 1'b1, 1'b0);
        tick_n(8);
        check_outs("ss_stop2", 8'h00, 3'b001, 1'b0, 1'b1);

        // One-clock halt during DEFER of an indirect TAD; run held high afterwards.
        do_reset();
        opcode = 3'd1;
        ind    = 1'b1;
        start();
        tick_n(10);
        check_outs("halt_defer_t2", 8'h04, 3'b010, 1'b1, 1'b0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick_n(5);
        check_outs("halt_exec_t0", 8'h01, 3'b100, 1'b1, 1'b0);
        tick_n(8);
        check_outs("halt_stop", 8'h00, 3'b001, 1'b0, 1'b1);
        tick_n(5);
        check_outs("halt_no_restart", 8'h00, 3'b001, 1'b0, 1'b0);

        // Run edge coinciding with halt while stopped: starts, halt not latched.
        halt = 1'b1;
        start();
        halt = 1'b0;
        check_outs("halt_start", 8'h01, 3'b001, 1'b1, 1'b0);
        tick_n(8);
        check_outs("halt_start_defer", 8'h01, 3'b010, 1'b1, 1'b0);

        // Asynchronous clear at T4 of EXEC.
        do_reset();
        opcode = 3'd1;
        ind    = 1'b0;
        start();
        tick_n(12);
        check_outs("clr_pre", 8'h10, 3'b100, 1'b1, 1'b0);
        #2;
        nclr = 1'b0;
        #1;
        check_outs("clr_async", 8'h00, 3'b001, 1'b0, 1'b0);
        run = 1'b0;
        tick();
        nclr = 1'b1;
        start();
        check_outs("clr_restart", 8'h01, 3'b001, 1'b1, 1'b0);

        // Randomized panel and IR activity against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(15) == 0) run = ~run;
            halt = ($urandom_range(23) == 0);
            if ($urandom_range(63) == 0) sstep = ~sstep;
            if ($urandom_range(5) == 0) begin
                opcode = 3'($urandom_range(7));
                ind    = 1'($urandom_range(1));
            end
            @(posedge clk);
            model_step();
            #1;
            check_outs($sformatf("rnd%0d", c), m_running ? 8'(1 << m_cnt) : 8'h00,
                       3'(1 << m_maj), m_running, m_done);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
